// File: rtl/spram_pkg.sv
// spram_pkg: shared types and constants for spram_responder and spram_array.
// ADDR_WIDTH / DATA_WIDTH normally come from define.v; the guarded fallbacks
// below carry the same values so the package compiles standalone.
// Optional feature macro used by the top: RAM_STATS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package spram_pkg;

    // Controller state: INIT zeroes the array, READY serves accesses
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // One read-pipeline stage: control flags travel with the read data
    typedef struct packed {
        logic                   valid;
        logic                   oe;
        logic                   err;
        logic [`DATA_WIDTH-1:0] data;
    } rd_stage_t;

    localparam int unsigned CNT_WIDTH = 32;

    // Saturating increment for the statistics counters
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/spram_array.sv
// spram_array: single-port storage, synchronous write, registered read.
// Read data for an address presented at edge N is visible after edge N.
module spram_array
    import spram_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic                   i_re,
    input  logic [AW-1:0]          i_addr,
    input  logic [`DATA_WIDTH-1:0] i_wdata,
    output logic [`DATA_WIDTH-1:0] o_rdata
);

    logic [`DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Write on request; register the addressed word on a read
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/spram_responder.sv
// spram_responder: single-port RAM front end with power-up clear,
// READ_LAT (1 or 2) cycle read pipeline, output enable gating and
// out-of-range detection. Define RAM_STATS_EN to add rd_cnt/wr_cnt.
module spram_responder
    import spram_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    oe,
    input  logic [`ADDR_WIDTH-1:0]  addr,
    input  logic                    W_req,
    input  logic [`DATA_WIDTH-1:0]  W_data,
    output logic [`DATA_WIDTH-1:0]  R_data,
    output logic                    rd_valid,
    output logic                    addr_err,
    output logic                    init_busy
`ifdef RAM_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]    rd_cnt,
    output logic [CNT_WIDTH-1:0]    wr_cnt
`endif
);

    localparam int unsigned            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [`ADDR_WIDTH:0]   DEPTH_EXT = (`ADDR_WIDTH+1)'(DEPTH);
    localparam logic [AW-1:0]          LAST_ADDR = AW'(DEPTH - 1);

    state_t                 r_state;
    logic [AW-1:0]          r_clr_addr;

    logic                   w_ready;
    logic                   w_in_range;
    logic                   w_rd_req;
    logic                   w_wr_req;
    logic                   w_arr_we;
    logic [AW-1:0]          w_arr_addr;
    logic [`DATA_WIDTH-1:0] w_arr_wdata;
    logic [`DATA_WIDTH-1:0] w_arr_rdata;

    logic                   r_s0_valid;
    logic                   r_s0_oe;
    logic                   r_s0_err;
    logic                   r_acc_err;

    rd_stage_t              w_s1_next;
    rd_stage_t              w_done;

    assign init_busy = (r_state == INIT);

    // FSM: walk the clear address through the array, then serve accesses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= INIT;
            r_clr_addr <= '0;
        end else if (r_state == INIT) begin
            if (r_clr_addr == LAST_ADDR) begin
                r_state <= READY;
            end
            r_clr_addr <= r_clr_addr + AW'(1);
        end
    end

    // Request decode and array port mux (clear owns the port during INIT)
    always_comb begin
        w_ready    = (r_state == READY);
        w_in_range = ({1'b0, addr} < DEPTH_EXT);
        w_wr_req   = w_ready && cs && W_req;
        w_rd_req   = w_ready && cs && !W_req;
        if (w_ready) begin
            w_arr_we    = w_wr_req && w_in_range;
            w_arr_addr  = addr[AW-1:0];
            w_arr_wdata = W_data;
        end else begin
            w_arr_we    = 1'b1;
            w_arr_addr  = r_clr_addr;
            w_arr_wdata = '0;
        end
    end

    spram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_re    (w_rd_req),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    // Issue stage: latch per-read flags in step with the array's read register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_oe    <= 1'b0;
            r_s0_err   <= 1'b0;
            r_acc_err  <= 1'b0;
        end else begin
            r_s0_valid <= w_rd_req;
            r_s0_oe    <= oe;
            r_s0_err   <= !w_in_range;
            r_acc_err  <= (w_rd_req || w_wr_req) && !w_in_range;
        end
    end

    // Combine latched flags with the array output into a full stage record
    always_comb begin
        w_s1_next       = '0;
        w_s1_next.valid = r_s0_valid;
        w_s1_next.oe    = r_s0_oe;
        w_s1_next.err   = r_s0_err;
        w_s1_next.data  = w_arr_rdata;
    end

    if (READ_LAT == 2) begin : g_lat2
        rd_stage_t r_s1;

        // Extra pipeline stage for two-cycle read latency
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1 <= '0;
            end else begin
                r_s1 <= w_s1_next;
            end
        end

        assign w_done = r_s1;
    end else begin : g_lat1
        assign w_done = w_s1_next;
    end

    // Output register: update only on an enabled read; out-of-range reads give 0
    always_ff @(posedge clk) begin
        if (rst) begin
            R_data   <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= w_done.valid && w_done.oe;
            addr_err <= r_acc_err;
            if (w_done.valid && w_done.oe) begin
                R_data <= w_done.err ? '0 : w_done.data;
            end
        end
    end

`ifdef RAM_STATS_EN
    // Saturating counts of accepted READY reads and writes
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (w_rd_req) begin
                rd_cnt <= sat_inc(rd_cnt);
            end
            if (w_wr_req) begin
                wr_cnt <= sat_inc(wr_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_spram_responder.sv
// tb_spram_responder: directed bench driving two DEPTH=16 instances
// (READ_LAT=1 and READ_LAT=2) with identical stimulus.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_spram_responder;

    localparam int unsigned DEPTH = 16;

    logic                   clk;
    logic                   rst;
    logic                   cs;
    logic                   oe;
    logic                   W_req;
    logic [`ADDR_WIDTH-1:0] addr;
    logic [`DATA_WIDTH-1:0] W_data;
    logic [`DATA_WIDTH-1:0] R_data1, R_data2;
    logic                   rd_valid1, rd_valid2;
    logic                   addr_err1, addr_err2;
    logic                   init_busy1, init_busy2;
`ifdef RAM_STATS_EN
    logic [31:0]            rd_cnt1, wr_cnt1, rd_cnt2, wr_cnt2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Operation table consumed by run_seq
    logic                   s_we   [0:31];
    logic [`ADDR_WIDTH-1:0] s_addr [0:31];
    logic [`DATA_WIDTH-1:0] s_data [0:31];
    logic                   s_oe   [0:31];

    // Per-step observations: bit k / entry k is sampled after edge k
    logic [31:0]            v1, v2, e1, e2;
    logic [`DATA_WIDTH-1:0] d1 [0:31];
    logic [`DATA_WIDTH-1:0] d2 [0:31];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spram_responder #(.DEPTH(DEPTH), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .cs(cs), .oe(oe), .addr(addr), .W_req(W_req),
        .W_data(W_data), .R_data(R_data1), .rd_valid(rd_valid1),
        .addr_err(addr_err1), .init_busy(init_busy1)
`ifdef RAM_STATS_EN
        , .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
`endif
    );

    spram_responder #(.DEPTH(DEPTH), .READ_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .cs(cs), .oe(oe), .addr(addr), .W_req(W_req),
        .W_data(W_data), .R_data(R_data2), .rd_valid(rd_valid2),
        .addr_err(addr_err2), .init_busy(init_busy2)
`ifdef RAM_STATS_EN
        , .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs     = 1'b0;
        W_req  = 1'b0;
        oe     = 1'b0;
        addr   = '0;
        W_data = '0;
    endtask

    task automatic set_op(input int i, input logic we, input int a,
                          input logic [`DATA_WIDTH-1:0] d, input logic o);
        s_we[i]   = we;
        s_addr[i] = `ADDR_WIDTH'(a);
        s_data[i] = d;
        s_oe[i]   = o;
    endtask

    // Apply ops 0..n-1 on consecutive edges, then idle for two edges
    task automatic run_seq(input int n);
        v1 = '0; v2 = '0; e1 = '0; e2 = '0;
        for (int k = 0; k < n + 2; k++) begin
            if (k < n) begin
                cs = 1'b1; W_req = s_we[k]; addr = s_addr[k];
                W_data = s_data[k]; oe = s_oe[k];
            end else begin
                idle();
            end
            tick();
            v1[k] = rd_valid1; v2[k] = rd_valid2;
            e1[k] = addr_err1; e2[k] = addr_err2;
            d1[k] = R_data1;   d2[k] = R_data2;
        end
        idle();
    endtask

    // Count observed INIT cycles (including the current one) and any output activity
    task automatic wait_init(input bit noisy, output int busy1, output int busy2, output int leak);
        busy1 = init_busy1 ? 1 : 0;
        busy2 = init_busy2 ? 1 : 0;
        leak  = 0;
        if (noisy) begin
            cs = 1'b1; W_req = 1'b1; addr = `ADDR_WIDTH'(3); W_data = '1; oe = 1'b1;
        end
        for (int k = 0; k < 64; k++) begin
            if (noisy && k == 8) begin
                W_req = 1'b0; addr = `ADDR_WIDTH'(20);
            end
            tick();
            if (init_busy1) busy1++;
            if (init_busy2) busy2++;
            if (rd_valid1 || rd_valid2 || addr_err1 || addr_err2) leak++;
            if (!init_busy1 && !init_busy2) break;
        end
        idle();
        repeat (2) begin
            tick();
            if (rd_valid1 || rd_valid2 || addr_err1 || addr_err2) leak++;
        end
    endtask

    task automatic test_reset();
        int b1, b2, lk;
        idle();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (R_data1 !== '0)   begin n_fail++; $display("FAIL reset_rdata_lat1: got %h expected 0", R_data1); end
        n_checks++; if (R_data2 !== '0)   begin n_fail++; $display("FAIL reset_rdata_lat2: got %h expected 0", R_data2); end
        n_checks++; if ({rd_valid1, rd_valid2, addr_err1, addr_err2} !== 4'b0000)
            begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {rd_valid1, rd_valid2, addr_err1, addr_err2}); end
        n_checks++; if ({init_busy1, init_busy2} !== 2'b11)
            begin n_fail++; $display("FAIL reset_init_busy: got %b expected 11", {init_busy1, init_busy2}); end
        rst = 1'b0;
        wait_init(1'b1, b1, b2, lk);
        n_checks++; if (b1 != 16) begin n_fail++; $display("FAIL init_cycles_lat1: got %0d expected 16", b1); end
        n_checks++; if (b2 != 16) begin n_fail++; $display("FAIL init_cycles_lat2: got %0d expected 16", b2); end
        n_checks++; if (lk != 0)  begin n_fail++; $display("FAIL init_ignores_access: got %0d pulses expected 0", lk); end
    endtask

    task automatic test_init_clear();
        for (int i = 0; i < 16; i++) set_op(i, 1'b0, i, '0, 1'b1);
        run_seq(16);
        n_checks++; if (v1 !== 32'h0001_FFFE) begin n_fail++; $display("FAIL clear_valid_lat1: got %h expected %h", v1, 32'h0001_FFFE); end
        n_checks++; if (v2 !== 32'h0003_FFFC) begin n_fail++; $display("FAIL clear_valid_lat2: got %h expected %h", v2, 32'h0003_FFFC); end
        n_checks++; if ((e1 | e2) !== 32'h0) begin n_fail++; $display("FAIL clear_addr_err: got %h expected 0", e1 | e2); end
        for (int k = 0; k < 18; k++) begin
            n_checks++;
            if (d1[k] !== '0 || d2[k] !== '0) begin
                n_fail++; $display("FAIL clear_data step %0d: got %h/%h expected 0/0", k, d1[k], d2[k]);
            end
        end
    endtask

    task automatic test_read_after_write();
        set_op(0, 1'b1, 5, 32'hDEAD_BEEF, 1'b0);
        set_op(1, 1'b0, 5, '0, 1'b1);
        run_seq(2);
        n_checks++; if (v1 !== 32'h4) begin n_fail++; $display("FAIL raw_valid_lat1: got %h expected %h", v1, 32'h4); end
        n_checks++; if (v2 !== 32'h8) begin n_fail++; $display("FAIL raw_valid_lat2: got %h expected %h", v2, 32'h8); end
        n_checks++; if (d1[2] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL raw_data_lat1: got %h expected deadbeef", d1[2]); end
        n_checks++; if (d2[2] !== 32'h0) begin n_fail++; $display("FAIL raw_early_lat2: got %h expected 0", d2[2]); end
        n_checks++; if (d2[3] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL raw_data_lat2: got %h expected deadbeef", d2[3]); end
    endtask

    task automatic test_back_to_back();
        set_op(0, 1'b1, 1, 32'h1111_0001, 1'b0);
        set_op(1, 1'b1, 2, 32'h2222_0002, 1'b0);
        set_op(2, 1'b1, 3, 32'h3333_0003, 1'b0);
        set_op(3, 1'b0, 1, '0, 1'b1);
        set_op(4, 1'b0, 2, '0, 1'b1);
        set_op(5, 1'b0, 3, '0, 1'b1);
        run_seq(6);
        n_checks++; if (v1 !== 32'h70) begin n_fail++; $display("FAIL b2b_valid_lat1: got %h expected %h", v1, 32'h70); end
        n_checks++; if (v2 !== 32'hE0) begin n_fail++; $display("FAIL b2b_valid_lat2: got %h expected %h", v2, 32'hE0); end
        n_checks++; if ({d1[4], d1[5], d1[6]} !== {32'h1111_0001, 32'h2222_0002, 32'h3333_0003})
            begin n_fail++; $display("FAIL b2b_data_lat1: got %h %h %h expected 11110001 22220002 33330003", d1[4], d1[5], d1[6]); end
        n_checks++; if ({d2[5], d2[6], d2[7]} !== {32'h1111_0001, 32'h2222_0002, 32'h3333_0003})
            begin n_fail++; $display("FAIL b2b_data_lat2: got %h %h %h expected 11110001 22220002 33330003", d2[5], d2[6], d2[7]); end
    endtask

    task automatic test_oe_gate();
        set_op(0, 1'b1, 7, 32'h0000_1234, 1'b0);
        set_op(1, 1'b0, 7, '0, 1'b1);
        set_op(2, 1'b0, 5, '0, 1'b0);
        run_seq(3);
        n_checks++; if (v1 !== 32'h4) begin n_fail++; $display("FAIL oe_valid_lat1: got %h expected %h", v1, 32'h4); end
        n_checks++; if (v2 !== 32'h8) begin n_fail++; $display("FAIL oe_valid_lat2: got %h expected %h", v2, 32'h8); end
        n_checks++; if ({d1[2], d1[3], d1[4]} !== {3{32'h0000_1234}})
            begin n_fail++; $display("FAIL oe_hold_lat1: got %h %h %h expected 00001234 x3", d1[2], d1[3], d1[4]); end
        n_checks++; if ({d2[3], d2[4]} !== {2{32'h0000_1234}})
            begin n_fail++; $display("FAIL oe_hold_lat2: got %h %h expected 00001234 x2", d2[3], d2[4]); end
    endtask

    task automatic test_range_err();
        set_op(0, 1'b1, 4, 32'h55AA_55AA, 1'b0);
        set_op(1, 1'b1, 20, 32'hCAFE_F00D, 1'b0);
        set_op(2, 1'b0, 20, '0, 1'b1);
        set_op(3, 1'b0, 4, '0, 1'b1);
        run_seq(4);
        n_checks++; if (e1 !== 32'h0C) begin n_fail++; $display("FAIL range_err_lat1: got %h expected %h", e1, 32'h0C); end
        n_checks++; if (e2 !== 32'h0C) begin n_fail++; $display("FAIL range_err_lat2: got %h expected %h", e2, 32'h0C); end
        n_checks++; if (v1 !== 32'h18) begin n_fail++; $display("FAIL range_valid_lat1: got %h expected %h", v1, 32'h18); end
        n_checks++; if (v2 !== 32'h30) begin n_fail++; $display("FAIL range_valid_lat2: got %h expected %h", v2, 32'h30); end
        n_checks++; if ({d1[3], d1[4]} !== {32'h0, 32'h55AA_55AA})
            begin n_fail++; $display("FAIL range_data_lat1: got %h %h expected 00000000 55aa55aa", d1[3], d1[4]); end
        n_checks++; if ({d2[4], d2[5]} !== {32'h0, 32'h55AA_55AA})
            begin n_fail++; $display("FAIL range_data_lat2: got %h %h expected 00000000 55aa55aa", d2[4], d2[5]); end
    endtask

    task automatic test_reset_mid_op();
        int b1, b2, lk;
        // read of addr 5 (deadbeef) cut off by reset on the next edge
        cs = 1'b1; W_req = 1'b0; addr = `ADDR_WIDTH'(5); oe = 1'b1;
        tick();
        idle();
        rst = 1'b1;
        tick();
        n_checks++; if ({rd_valid1, rd_valid2} !== 2'b00)
            begin n_fail++; $display("FAIL midread_valid_a: got %b expected 00", {rd_valid1, rd_valid2}); end
        n_checks++; if (R_data1 !== '0 || R_data2 !== '0)
            begin n_fail++; $display("FAIL midread_rdata: got %h/%h expected 0/0", R_data1, R_data2); end
        rst = 1'b0;
        tick();
        n_checks++; if ({rd_valid1, rd_valid2, R_data2 == '0} !== 3'b001)
            begin n_fail++; $display("FAIL midread_valid_b: got %b %h expected 00 0", {rd_valid1, rd_valid2}, R_data2); end
        // clear address now 1; advance to 7 and reset again
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_init(1'b0, b1, b2, lk);
        n_checks++; if (b1 != 16) begin n_fail++; $display("FAIL restart_cycles_lat1: got %0d expected 16", b1); end
        n_checks++; if (b2 != 16) begin n_fail++; $display("FAIL restart_cycles_lat2: got %0d expected 16", b2); end
        n_checks++; if (lk != 0)  begin n_fail++; $display("FAIL restart_pulses: got %0d expected 0", lk); end
    endtask

    task automatic test_post_reset();
`ifdef RAM_STATS_EN
        n_checks++; if ({rd_cnt1, wr_cnt1, rd_cnt2, wr_cnt2} !== '0)
            begin n_fail++; $display("FAIL stats_reset: got %0d %0d %0d %0d expected 0", rd_cnt1, wr_cnt1, rd_cnt2, wr_cnt2); end
`endif
        set_op(0, 1'b1, 6, 32'h0000_0077, 1'b0);
        set_op(1, 1'b1, 8, 32'h0000_0088, 1'b0);
        set_op(2, 1'b0, 5, '0, 1'b1);
        set_op(3, 1'b0, 6, '0, 1'b1);
        set_op(4, 1'b0, 8, '0, 1'b1);
        run_seq(5);
        n_checks++; if (v1 !== 32'h38) begin n_fail++; $display("FAIL post_valid_lat1: got %h expected %h", v1, 32'h38); end
        n_checks++; if (v2 !== 32'h70) begin n_fail++; $display("FAIL post_valid_lat2: got %h expected %h", v2, 32'h70); end
        n_checks++; if ({d1[3], d1[4], d1[5]} !== {32'h0, 32'h77, 32'h88})
            begin n_fail++; $display("FAIL post_data_lat1: got %h %h %h expected 0 77 88", d1[3], d1[4], d1[5]); end
        n_checks++; if ({d2[4], d2[5], d2[6]} !== {32'h0, 32'h77, 32'h88})
            begin n_fail++; $display("FAIL post_data_lat2: got %h %h %h expected 0 77 88", d2[4], d2[5], d2[6]); end
`ifdef RAM_STATS_EN
        n_checks++; if (rd_cnt1 !== 32'd3 || rd_cnt2 !== 32'd3)
            begin n_fail++; $display("FAIL stats_rd_cnt: got %0d/%0d expected 3", rd_cnt1, rd_cnt2); end
        n_checks++; if (wr_cnt1 !== 32'd2 || wr_cnt2 !== 32'd2)
            begin n_fail++; $display("FAIL stats_wr_cnt: got %0d/%0d expected 2", wr_cnt1, wr_cnt2); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_init_clear();
        test_read_after_write();
        test_back_to_back();
        test_oe_gate();
        test_range_err();
        test_reset_mid_op();
        test_post_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spram_responder.md
SPRAM_RESPONDER -- requirements
Module: spram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, giving the number of storage words (1..2**`ADDR_WIDTH).
REQ-002 SHALL have parameter READ_LAT, default 1, giving the read latency in cycles; the legal values are 1 and 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port cs, input, 1, chip select; no access occurs while it is low.
REQ-006 SHALL have port oe, input, 1, output enable sampled with a read request.
REQ-007 SHALL have port addr, input, `ADDR_WIDTH, the word address.
REQ-008 SHALL have port W_req, input, 1, write request, qualified by cs.
REQ-009 SHALL have port W_data, input, `DATA_WIDTH, the write data.
REQ-010 SHALL have port R_data, output, `DATA_WIDTH, registered read data.
REQ-011 SHALL have port rd_valid, output, 1, a one-cycle pulse when R_data is updated.
REQ-012 SHALL have port addr_err, output, 1, a one-cycle pulse on an out-of-range access.
REQ-013 SHALL have port init_busy, output, 1, high while the array is being cleared.

Function
REQ-014 SHALL implement a two-state FSM: INIT clears the array, then READY serves accesses.
REQ-015 In INIT the block SHALL write 0 to one word per cycle, at addresses 0 to DEPTH-1 in order, then enter READY on the next cycle.
- init_busy = 1 exactly while the FSM is in INIT.
- The clear takes DEPTH cycles.
REQ-016 In INIT, all cs/W_req/oe activity SHALL be ignored: no write, no read, no addr_err.
REQ-017 In READY, cs=1 with W_req=1 SHALL write W_data to mem[addr] at the clock edge.
- A write leaves R_data unchanged and does not pulse rd_valid.
REQ-018 In READY, cs=1 with W_req=0 SHALL issue a read of mem[addr].
- The data appears on R_data READ_LAT cycles after the issue edge.
- rd_valid pulses in the same cycle the data appears.
REQ-019 A read issued with oe=0 SHALL travel through the pipeline but SHALL NOT update R_data or pulse rd_valid.
REQ-020 R_data SHALL hold its last value whenever no qualifying read completes.
REQ-021 The block SHALL accept back-to-back reads every cycle (full throughput at both latencies).
REQ-022 Read-after-write to the same address on consecutive cycles SHALL return the newly written data.
REQ-023 An access with addr >= DEPTH SHALL be handled as follows:
- A write is dropped.
- A read completes normally but returns 0.
- addr_err pulses one cycle after the issue edge.
REQ-024 The read pipeline SHALL carry a valid bit, the oe flag and the range-error flag per stage, so that completion timing does not depend on later inputs.

Reset
REQ-025 When rst=1, the block SHALL on that edge:
- drive R_data = 0, rd_valid = 0 and addr_err = 0;
- flush every read in flight;
- enter INIT with the clear address at 0, so init_busy = 1 on the following cycle.
REQ-026 A reset asserted mid-clear SHALL restart the clear from address 0.
REQ-027 A reset asserted mid-read SHALL discard the read, with no rd_valid pulse.
REQ-028 Storage contents are not reset directly; they SHALL be zeroed only by the INIT sequence.

Configuration
REQ-029 Macro RAM_STATS_EN SHALL control a statistics feature.
- When RAM_STATS_EN is defined, the block adds output ports rd_cnt[31:0] and wr_cnt[31:0].
- The counters count accepted READY reads and writes, including out-of-range ones.
- The counters saturate at 32'hFFFF_FFFF and reset to 0.
REQ-030 When RAM_STATS_EN is undefined, the counter ports and logic SHALL be absent.
- All other behaviour is identical.

Structure
REQ-031 A shared package spram_pkg SHALL hold:
- the FSM state enum (INIT, READY);
- the pipeline-stage struct (valid, oe, err, data);
- the counter width constant (32).
REQ-032 One sub-module, spram_array, SHALL contain the storage array: a synchronous-write, registered-read array with one read/write port.
- The FSM, pipeline and counters remain in spram_responder.
REQ-033 The block SHALL use the `ADDR_WIDTH and `DATA_WIDTH macros from define.v.

Verification
REQ-034 Reset then idle with DEPTH=16 -> init_busy high for exactly 16 cycles; afterwards every read returns 0.
REQ-035 READ_LAT=1: write 32'hDEADBEEF to addr 5, then read addr 5 on the next cycle with oe=1 -> R_data=32'hDEADBEEF and rd_valid=1 exactly one cycle after the read issues.
REQ-036 READ_LAT=2: reads of addrs 1, 2, 3 on consecutive cycles -> three consecutive rd_valid pulses, starting 2 cycles after the first issue, in order.
REQ-037 Read with oe=0 after R_data=32'h1234 -> R_data stays 32'h1234 and no rd_valid pulse.
REQ-038 DEPTH=16, write to addr 20 then read addr 20 -> addr_err pulses twice, the read returns 0, and mem[4] is unchanged.
REQ-039 Assert rst at clear address 7, then release -> the clear restarts at 0 and takes 16 cycles. With RAM_STATS_EN defined: 3 reads and 2 writes -> rd_cnt=3 and wr_cnt=2.
